// File: rtl/bn_defs_pkg.sv
// Shared definitions for the get_best_neighbor scanner.
// Holds the FSM state encoding, the sentinel Q / hop values, the
// table byte offsets and a signed-compare helper.
package bn_defs_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CNT_A = 3'd1,
    ST_CNT_D = 3'd2,
    ST_ID_A  = 3'd3,
    ST_ID_D  = 3'd4,
    ST_Q_A   = 3'd5,
    ST_Q_D   = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  // Lowest signed Q value; also the "no best yet" marker.
  localparam logic [WORD_W-1:0] Q_MIN  = 16'h8000;
  // Hop ID reported when no entry has won.
  localparam logic [WORD_W-1:0] NO_HOP = 16'hFFFF;

  // Byte offsets from the table base (entry 0 for ID and Q).
  localparam logic [WORD_W-1:0] CNT_OFF = 16'd0;
  localparam logic [WORD_W-1:0] ID_OFF  = 16'd2;
  localparam logic [WORD_W-1:0] Q_OFF   = 16'd4;

  // Strict signed greater-than on 16-bit Q values.
  function automatic logic q_gt(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
    return $signed(a) > $signed(b);
  endfunction

endpackage

// File: rtl/get_best_neighbor_q_max_cmp.sv
// q_max_cmp: combinational signed compare-and-select of a candidate
// against the running best (and, with RUNNER_UP_EN, the runner-up).
// Macro: RUNNER_UP_EN adds the runner-up inputs/outputs.
// Ports:
//   best_q_i/best_id_i   running best Q and its ID
//   cand_q_i/cand_id_i   candidate Q and ID
//   sec_q_i/sec_id_i     running runner-up (RUNNER_UP_EN only)
//   best_q_o/best_id_o   updated best
//   sec_q_o/sec_id_o     updated runner-up (RUNNER_UP_EN only)
module q_max_cmp
  import bn_defs_pkg::*;
(
  input  logic [15:0] best_q_i,
  input  logic [15:0] best_id_i,
  input  logic [15:0] cand_q_i,
  input  logic [15:0] cand_id_i,
`ifdef RUNNER_UP_EN
  input  logic [15:0] sec_q_i,
  input  logic [15:0] sec_id_i,
  output logic [15:0] sec_q_o,
  output logic [15:0] sec_id_o,
`endif
  output logic [15:0] best_q_o,
  output logic [15:0] best_id_o
);

  // Strict compare keeps the earliest entry on ties.
  always_comb begin
    best_q_o  = best_q_i;
    best_id_o = best_id_i;
`ifdef RUNNER_UP_EN
    sec_q_o   = sec_q_i;
    sec_id_o  = sec_id_i;
`endif
    if (q_gt(cand_q_i, best_q_i)) begin
      best_q_o  = cand_q_i;
      best_id_o = cand_id_i;
`ifdef RUNNER_UP_EN
      // Displaced best becomes the runner-up.
      sec_q_o   = best_q_i;
      sec_id_o  = best_id_i;
    end else if (q_gt(cand_q_i, sec_q_i)) begin
      sec_q_o   = cand_q_i;
      sec_id_o  = cand_id_i;
`endif
    end
  end

endmodule

// File: rtl/get_best_neighbor.sv
// get_best_neighbor: read-only scanner over the neighbor table in the
// shared 16-bit-word memory. On start it reads the entry count, walks
// min(count, MAX_NEIGHBORS) (ID, Q) entries and reports the entry with
// the highest signed Q.
// Macro: RUNNER_UP_EN adds second_hop/second_q outputs.
// Ports:
//   clock, rst         clock and synchronous active-high reset
//   start              begin a scan (only honoured in IDLE)
//   address, wr_en     memory byte address (registered), write enable (0)
//   mem_data_out       memory read word, valid the cycle after address
//   nexthop, best_q    ID and Q of the best entry
//   valid              at least one entry was scanned
//   busy, done         scan in progress / one-cycle completion pulse
//   second_hop, second_q  runner-up ID and Q (RUNNER_UP_EN only)
module get_best_neighbor
  import bn_defs_pkg::*;
#(
  parameter logic [15:0] TABLE_BASE    = 16'h0400,
  parameter int unsigned MAX_NEIGHBORS = 16,
  parameter int unsigned ENTRY_BYTES   = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] address,
  output logic        wr_en,
  input  logic [15:0] mem_data_out,
  output logic [15:0] nexthop,
  output logic [15:0] best_q,
  output logic        valid,
  output logic        busy,
`ifdef RUNNER_UP_EN
  output logic [15:0] second_hop,
  output logic [15:0] second_q,
`endif
  output logic        done
);

  localparam logic [15:0] MAX_N     = 16'(MAX_NEIGHBORS);
  localparam logic [15:0] STRIDE    = 16'(ENTRY_BYTES);
  localparam logic [15:0] ID_TO_Q   = Q_OFF - ID_OFF;

  state_e      state_q, state_d;
  logic [15:0] address_q, address_d;
  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] cand_id_q, cand_id_d;
  logic [15:0] run_best_q, run_best_d;
  logic [15:0] run_id_q, run_id_d;
  logic [15:0] nexthop_q, nexthop_d;
  logic [15:0] out_best_q, out_best_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] cnt_clamped;
  logic [15:0] cmp_best_q, cmp_best_id;
`ifdef RUNNER_UP_EN
  logic [15:0] sec_best_q, sec_best_d;
  logic [15:0] sec_id_q, sec_id_d;
  logic [15:0] out_sec_hop_q, out_sec_hop_d;
  logic [15:0] out_sec_q_q, out_sec_q_d;
  logic [15:0] cmp_sec_q, cmp_sec_id;
`endif

  // Candidate Q arrives on mem_data_out while in ST_Q_D.
  q_max_cmp u_cmp (
    .best_q_i  (run_best_q),
    .best_id_i (run_id_q),
    .cand_q_i  (mem_data_out),
    .cand_id_i (cand_id_q),
`ifdef RUNNER_UP_EN
    .sec_q_i   (sec_best_q),
    .sec_id_i  (sec_id_q),
    .sec_q_o   (cmp_sec_q),
    .sec_id_o  (cmp_sec_id),
`endif
    .best_q_o  (cmp_best_q),
    .best_id_o (cmp_best_id)
  );

  // Count word is unsigned; clamp to the scan limit.
  assign cnt_clamped = (mem_data_out > MAX_N) ? MAX_N : mem_data_out;

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    n_d        = n_q;
    idx_d      = idx_q;
    cand_id_d  = cand_id_q;
    run_best_d = run_best_q;
    run_id_d   = run_id_q;
    nexthop_d  = nexthop_q;
    out_best_d = out_best_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
`ifdef RUNNER_UP_EN
    sec_best_d    = sec_best_q;
    sec_id_d      = sec_id_q;
    out_sec_hop_d = out_sec_hop_q;
    out_sec_q_d   = out_sec_q_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CNT_A;
          address_d  = TABLE_BASE + CNT_OFF;
          run_best_d = Q_MIN;
          run_id_d   = NO_HOP;
          idx_d      = 16'd0;
`ifdef RUNNER_UP_EN
          sec_best_d = Q_MIN;
          sec_id_d   = NO_HOP;
`endif
        end
      end
      ST_CNT_A: state_d = ST_CNT_D;
      ST_CNT_D: begin
        n_d   = cnt_clamped;
        idx_d = 16'd0;
        if (cnt_clamped == 16'd0) begin
          state_d = ST_DONE;
        end else begin
          state_d   = ST_ID_A;
          address_d = TABLE_BASE + ID_OFF;
        end
      end
      ST_ID_A: state_d = ST_ID_D;
      ST_ID_D: begin
        cand_id_d = mem_data_out;
        state_d   = ST_Q_A;
        address_d = address_q + ID_TO_Q;
      end
      ST_Q_A: state_d = ST_Q_D;
      ST_Q_D: begin
        run_best_d = cmp_best_q;
        run_id_d   = cmp_best_id;
`ifdef RUNNER_UP_EN
        sec_best_d = cmp_sec_q;
        sec_id_d   = cmp_sec_id;
`endif
        idx_d = idx_q + 16'd1;
        if (idx_d == n_q) begin
          state_d = ST_DONE;
        end else begin
          state_d   = ST_ID_A;
          // Step from this entry's Q word to the next entry's ID word.
          address_d = address_q - ID_TO_Q + STRIDE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Results publish on entry to DONE so they coincide with the done pulse.
    if (state_d == ST_DONE) begin
      done_d     = 1'b1;
      nexthop_d  = run_id_d;
      out_best_d = run_best_d;
      valid_d    = (n_d != 16'd0);
`ifdef RUNNER_UP_EN
      out_sec_hop_d = sec_id_d;
      out_sec_q_d   = sec_best_d;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      address_q  <= 16'd0;
      n_q        <= 16'd0;
      idx_q      <= 16'd0;
      cand_id_q  <= NO_HOP;
      run_best_q <= Q_MIN;
      run_id_q   <= NO_HOP;
      nexthop_q  <= NO_HOP;
      out_best_q <= Q_MIN;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef RUNNER_UP_EN
      sec_best_q    <= Q_MIN;
      sec_id_q      <= NO_HOP;
      out_sec_hop_q <= NO_HOP;
      out_sec_q_q   <= Q_MIN;
`endif
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      cand_id_q  <= cand_id_d;
      run_best_q <= run_best_d;
      run_id_q   <= run_id_d;
      nexthop_q  <= nexthop_d;
      out_best_q <= out_best_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef RUNNER_UP_EN
      sec_best_q    <= sec_best_d;
      sec_id_q      <= sec_id_d;
      out_sec_hop_q <= out_sec_hop_d;
      out_sec_q_q   <= out_sec_q_d;
`endif
    end
  end

  assign address = address_q;
  assign wr_en   = 1'b0;
  assign nexthop = nexthop_q;
  assign best_q  = out_best_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef RUNNER_UP_EN
  assign second_hop = out_sec_hop_q;
  assign second_q   = out_sec_q_q;
`endif

endmodule
